butterfly_r2_seq: RTL and testbench



---
 rtl/butterfly_r2_seq_pkg.sv | 20 ++
 rtl/butterfly_r2_seq_if.sv | 10 +
 rtl/butterfly_r2_seq_out_stage.sv | 30 +++
 rtl/butterfly_r2_seq.sv | 118 +++++++++++
 tb/tb_butterfly_r2_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/butterfly_r2_seq_pkg.sv
// butterfly_r2_seq_pkg: shared FFT constants, butterfly FSM states and fixed-point helpers
package butterfly_r2_seq_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;

    typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_WX, S_WY} state_t;

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] p, input int tw);
        return (p + (64'sd1 <<< (tw - 2))) >>> (tw - 1);
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/butterfly_r2_seq_if.sv
// butterfly_r2_seq_if: operand/twiddle request and result write bus of the serial butterfly
interface butterfly_r2_seq_if #(parameter int DW = 16, parameter int TW = 16);
    logic                 bf_go, bf_busy, bf_done, scale, inv, wren, out_sel, ovf;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im, out_re, out_im;
    logic signed [TW-1:0] w_re, w_im;
    modport master(output bf_go, a_re, a_im, b_re, b_im, w_re, w_im, scale, inv,
                   input bf_busy, bf_done, wren, out_sel, out_re, out_im, ovf);
    modport slave(input bf_go, a_re, a_im, b_re, b_im, w_re, w_im, scale, inv,
                  output bf_busy, bf_done, wren, out_sel, out_re, out_im, ovf);
endinterface

// File: rtl/butterfly_r2_seq_out_stage.sv
// bf_out_stage: A +/- t with optional halving, saturation to DW bits and clip flag
module bf_out_stage import butterfly_r2_seq_pkg::*; #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW+1:0] t_re,
    input  logic signed [DW+1:0] t_im,
    input  logic                 sub,
    input  logic                 scale,
    output logic signed [DW-1:0] o_re,
    output logic signed [DW-1:0] o_im,
    output logic                 ovf
);
    logic signed [DW+2:0] s_re, s_im, c_re, c_im;
    logic signed [63:0]   q_re, q_im;

    // DW+3 bits hold any A +/- t without wrap, so clipping is decided on the true value
    always_comb begin
        s_re = sub ? (DW+3)'(a_re) - (DW+3)'(t_re) : (DW+3)'(a_re) + (DW+3)'(t_re);
        s_im = sub ? (DW+3)'(a_im) - (DW+3)'(t_im) : (DW+3)'(a_im) + (DW+3)'(t_im);
        c_re = scale ? (DW+3)'((s_re + 1) >>> 1) : s_re;
        c_im = scale ? (DW+3)'((s_im + 1) >>> 1) : s_im;
        q_re = sat(64'(c_re), DW);
        q_im = sat(64'(c_im), DW);
        o_re = DW'(q_re);
        o_im = DW'(q_im);
        ovf  = q_re != 64'(c_re) || q_im != 64'(c_im);
    end
endmodule

// File: rtl/butterfly_r2_seq.sv
// butterfly_r2_seq: radix-2 DIT butterfly X = A + W*B, Y = A - W*B on one shared multiplier
module butterfly_r2_seq import butterfly_r2_seq_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input logic              clk,
    input logic              rst_n,
    butterfly_r2_seq_if.slave bus
);
    state_t                  state_q, state_d;
    logic signed [DW-1:0]    a_re_q, a_im_q, b_re_q, b_im_q, a_re_d, a_im_d, b_re_d, b_im_d;
    logic signed [TW-1:0]    w_re_q, w_im_q, w_re_d, w_im_d;
    logic                    scale_q, inv_q, scale_d, inv_d;
    logic signed [DW:0]      p0_q, p1_q, p2_q, p3_q, p0_d, p1_d, p2_d, p3_d;
    logic                    busy_q, done_q, wren_q, sel_q, ovf_q, busy_d, done_d, wren_d, sel_d, ovf_d;
    logic signed [DW-1:0]    out_re_q, out_im_q, out_re_d, out_im_d;
    logic                    cap;
    logic signed [DW-1:0]    m_b;
    logic signed [TW-1:0]    m_w;
    logic signed [DW+TW-1:0] prod;
    logic signed [DW:0]      rnd;
    logic signed [DW+1:0]    t_re, t_im;
    logic signed [DW-1:0]    s_re, s_im;
    logic                    s_ovf;

    bf_out_stage #(.DW(DW)) u_out (
        .a_re(a_re_q), .a_im(a_im_q), .t_re(t_re), .t_im(t_im),
        .sub(state_q == S_WY), .scale(scale_q),
        .o_re(s_re), .o_im(s_im), .ovf(s_ovf)
    );

    // Sequencing, operand capture, one product per M state, twiddle product and result registers
    always_comb begin
        cap      = state_q == S_IDLE && bus.bf_go;
        state_d  = state_q == S_IDLE ? (bus.bf_go ? S_M0 : S_IDLE)
                 : state_q == S_WY ? S_IDLE : state_t'(state_q + 3'd1);
        a_re_d   = cap ? bus.a_re : a_re_q;
        a_im_d   = cap ? bus.a_im : a_im_q;
        b_re_d   = cap ? bus.b_re : b_re_q;
        b_im_d   = cap ? bus.b_im : b_im_q;
        w_re_d   = cap ? bus.w_re : w_re_q;
        w_im_d   = cap ? bus.w_im : w_im_q;
        scale_d  = cap ? bus.scale : scale_q;
        inv_d    = cap ? bus.inv : inv_q;
        m_b      = (state_q == S_M0 || state_q == S_M2) ? b_re_q : b_im_q;
        m_w      = (state_q == S_M0 || state_q == S_M3) ? w_re_q : w_im_q;
        prod     = m_b * m_w;
        rnd      = (DW+1)'(round_shift(64'(prod), TW));
        p0_d     = state_q == S_M0 ? rnd : p0_q;
        p1_d     = state_q == S_M1 ? rnd : p1_q;
        p2_d     = state_q == S_M2 ? rnd : p2_q;
        p3_d     = state_q == S_M3 ? rnd : p3_q;
        t_re     = inv_q ? (DW+2)'(p0_q) + (DW+2)'(p1_q) : (DW+2)'(p0_q) - (DW+2)'(p1_q);
        t_im     = inv_q ? (DW+2)'(p3_q) - (DW+2)'(p2_q) : (DW+2)'(p3_q) + (DW+2)'(p2_q);
        wren_d   = state_q == S_WX || state_q == S_WY;
        done_d   = state_q == S_WY;
        busy_d   = state_d != S_IDLE || state_q == S_WY;
        sel_d    = wren_d ? state_q == S_WY : sel_q;
        ovf_d    = wren_d ? s_ovf : ovf_q;
        out_re_d = wren_d ? s_re : out_re_q;
        out_im_d = wren_d ? s_im : out_im_q;
    end

    // All state registers; reset aborts any butterfly and clears every output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_re_q   <= '0;
            a_im_q   <= '0;
            b_re_q   <= '0;
            b_im_q   <= '0;
            w_re_q   <= '0;
            w_im_q   <= '0;
            scale_q  <= 1'b0;
            inv_q    <= 1'b0;
            p0_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wren_q   <= 1'b0;
            sel_q    <= 1'b0;
            ovf_q    <= 1'b0;
            out_re_q <= '0;
            out_im_q <= '0;
        end else begin
            state_q  <= state_d;
            a_re_q   <= a_re_d;
            a_im_q   <= a_im_d;
            b_re_q   <= b_re_d;
            b_im_q   <= b_im_d;
            w_re_q   <= w_re_d;
            w_im_q   <= w_im_d;
            scale_q  <= scale_d;
            inv_q    <= inv_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wren_q   <= wren_d;
            sel_q    <= sel_d;
            ovf_q    <= ovf_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

    assign bus.bf_busy = busy_q;
    assign bus.bf_done = done_q;
    assign bus.wren    = wren_q;
    assign bus.out_sel = sel_q;
    assign bus.ovf     = ovf_q;
    assign bus.out_re  = out_re_q;
    assign bus.out_im  = out_im_q;
endmodule

// File: tb/tb_butterfly_r2_seq.sv
// tb_butterfly_r2_seq: vector table plus scoreboard of expected X/Y writes for butterfly_r2_seq
module tb_butterfly_r2_seq;
    typedef struct {
        int a_re, a_im, b_re, b_im, w_re, w_im;
        bit scale, inv;
        int x_re, x_im;
        bit x_ovf;
        int y_re, y_im;
        bit y_ovf;
    } vec_t;

    typedef struct {
        int cyc;
        bit sel;
        int re, im;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t vecs[8];

    butterfly_r2_seq_if #(.DW(8), .TW(8)) bus();
    butterfly_r2_seq #(.DW(8), .TW(8)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.a_re  = 8'(v.a_re);
        bus.a_im  = 8'(v.a_im);
        bus.b_re  = 8'(v.b_re);
        bus.b_im  = 8'(v.b_im);
        bus.w_re  = 8'(v.w_re);
        bus.w_im  = 8'(v.w_im);
        bus.scale = v.scale;
        bus.inv   = v.inv;
        bus.bf_go = 1'b1;
    endtask

    task automatic scramble();
        bus.a_re  = 8'($urandom);
        bus.a_im  = 8'($urandom);
        bus.b_re  = 8'($urandom);
        bus.b_im  = 8'($urandom);
        bus.w_re  = 8'($urandom);
        bus.w_im  = 8'($urandom);
        bus.scale = 1'($urandom);
        bus.inv   = 1'($urandom);
    endtask

    task automatic push(input vec_t v, input int n);
        exp_t e;
        e = '{n + 5, 1'b0, v.x_re, v.x_im, v.x_ovf};
        sbq.push_back(e);
        e = '{n + 6, 1'b1, v.y_re, v.y_im, v.y_ovf};
        sbq.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
        chk("drain_timeout", sbq.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.bf_busy), 0);
        chk({tag, "_done"}, int'(bus.bf_done), 0);
        chk({tag, "_wren"}, int'(bus.wren), 0);
        chk({tag, "_sel"}, int'(bus.out_sel), 0);
        chk({tag, "_ovf"}, int'(bus.ovf), 0);
        chk({tag, "_re"}, int'(bus.out_re), 0);
        chk({tag, "_im"}, int'(bus.out_im), 0);
    endtask

    // Scoreboard: each write must match the oldest expected word on the expected cycle
    always @(negedge clk) begin
        exp_t e;
        if (bus.wren === 1'b1) begin
            if (sbq.size() == 0) chk("spurious_wren", 1, 0);
            else begin
                e = sbq.pop_front();
                chk(e.sel ? "y_cycle" : "x_cycle", cyc, e.cyc);
                chk("out_sel", int'(bus.out_sel), int'(e.sel));
                chk(e.sel ? "y_re" : "x_re", int'(bus.out_re), e.re);
                chk(e.sel ? "y_im" : "x_im", int'(bus.out_im), e.im);
                chk(e.sel ? "y_ovf" : "x_ovf", int'(bus.ovf), int'(e.ovf));
                chk("bf_done", int'(bus.bf_done), int'(e.sel));
            end
        end else begin
            if (bus.bf_done === 1'b1) chk("done_without_wren", 1, 0);
            if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                chk("missing_wren", cyc, sbq[0].cyc);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{10, 20, 40, -60, 64, 0, 1'b0, 1'b0, 30, -10, 1'b0, -10, 50, 1'b0};
        vecs[1] = '{10, 20, 40, -60, 64, 0, 1'b1, 1'b0, 15, -5, 1'b0, -5, 25, 1'b0};
        vecs[2] = '{0, 0, 40, -60, 0, 64, 1'b0, 1'b0, 30, 20, 1'b0, -30, -20, 1'b0};
        vecs[3] = '{0, 0, 40, -60, 0, 64, 1'b0, 1'b1, -30, -20, 1'b0, 30, 20, 1'b0};
        vecs[4] = '{120, 0, 100, 0, 64, 0, 1'b0, 1'b0, 127, 0, 1'b1, 70, 0, 1'b0};
        vecs[5] = '{120, 0, 100, 0, 64, 0, 1'b1, 1'b0, 85, 0, 1'b0, 35, 0, 1'b0};
        vecs[6] = '{0, 0, 3, -3, 64, 0, 1'b0, 1'b0, 2, -1, 1'b0, -2, 1, 1'b0};
        vecs[7] = '{-128, -128, 100, 100, 64, 0, 1'b0, 1'b0, -78, -78, 1'b0, -128, -128, 1'b1};
        bus.bf_go = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_zero("reset");

        // Single butterflies with busy-window check; operands scrambled right after capture
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            n = cyc + 1;
            push(vecs[i], n);
            @(negedge clk);
            bus.bf_go = 1'b0;
            scramble();
            for (int k = 0; k < 7; k++) begin
                chk("busy_high", int'(bus.bf_busy), 1);
                @(negedge clk);
            end
            chk("busy_low", int'(bus.bf_busy), 0);
        end
        drain();

        // A second go pulse while busy is dropped
        @(negedge clk);
        drive(vecs[0]);
        push(vecs[0], cyc + 1);
        @(negedge clk);
        bus.bf_go = 1'b0;
        @(negedge clk);
        bus.bf_go = 1'b1;
        @(negedge clk);
        bus.bf_go = 1'b0;
        drain();

        // go held high for 30 edges: acceptances every 7 cycles
        @(negedge clk);
        drive(vecs[2]);
        n = cyc + 1;
        for (int k = 0; k < 5; k++) push(vecs[2], n + 7 * k);
        repeat (30) @(negedge clk);
        bus.bf_go = 1'b0;
        drain();

        // Leave nonzero outputs with ovf=1, then abort a butterfly by reset at n+3
        @(negedge clk);
        drive(vecs[7]);
        push(vecs[7], cyc + 1);
        @(negedge clk);
        bus.bf_go = 1'b0;
        drain();
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        bus.bf_go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero("abort");
        @(negedge clk);
        drive(vecs[1]);
        push(vecs[1], cyc + 1);
        @(negedge clk);
        bus.bf_go = 1'b0;
        scramble();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
